riscv_alu_issue: RTL and testbench
==================================

# riscv_alu_issue

Registered issue stage directly upstream of the 64-bit RISC-V ALU. It accepts decoded operations from the decode stage over a valid/ready handshake and resolves operands. Operands are forwarded from the MEM and WB stages, and the immediate is substituted for B when selected. The stage buffers up to two operations in a skid buffer and presents `ALUControl`, `A` and `B` to the ALU, with `Rd`/`RegWrite` travelling alongside.

## Interface
- `XLEN`, 64, datapath width
- `REGW`, 5, register index width
- `clk` input 1 system clock
- `reset` input 1 asynchronous, active-high reset
- `InValid` input 1 decode offers an operation
- `InReady` output 1 stage can accept
- `InALUControl` input 4 ALU op code; same encoding the ALU decodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR
- `InRs1Val`, `InRs2Val`, `InImm` input XLEN register-file read values and sign-extended immediate
- `InALUSrc` input 1 1 = B takes `InImm`
- `InRs1`, `InRs2`, `InRd` input REGW source and destination indices
- `InRegWrite` input 1 operation writes `Rd`
- `FwdMRegWrite`, `FwdMRd`, `FwdMResult` input 1/REGW/XLEN MEM-stage producer
- `FwdWRegWrite`, `FwdWRd`, `FwdWResult` input 1/REGW/XLEN WB-stage producer
- `Flush` input 1 discard all buffered and incoming operations
- `OutValid` output 1 head entry valid
- `OutReady` input 1 ALU/EX consumer accepts head
- `ALUControl` output 4; `A`, `B` output XLEN; `OutRd` output REGW; `OutRegWrite` output 1 head entry fields

## Operation
- **Transfers.** Input transfer = `InValid & InReady`. Output transfer = `OutValid & OutReady`.
- **Operand resolution at acceptance.**
  - `fwdA` = `FwdMResult` if `FwdMRegWrite & FwdMRd==InRs1 & InRs1!=0`; else `FwdWResult` under the same WB conditions; else `InRs1Val`. MEM has priority over WB.
  - `fwdB` is resolved the same way on `InRs2`.
  - Stored A = `fwdA`. Stored B = `InALUSrc ? InImm : fwdB`. `InALUSrc` suppresses forwarding on B.
  - The decode hazard unit guarantees that producers older than WB are already in the register file. The stage never re-resolves operands after acceptance.
- **Buffer: two entries, `head` and `skid`.**
  - **EMPTY:** accept into head.
  - **ONE:** simultaneous in/out transfers replace head. Input only fills skid. Output only goes to EMPTY.
  - **FULL:** `InReady`=0. An output transfer moves skid to head and goes to ONE.
- `InReady` = skid empty, driven from a register, not combinational from `OutReady`.
- **Flush.** The next state is EMPTY regardless of any simultaneous input or output transfer. An input presented in the flush cycle is dropped, even if `InReady`=1.
- `ALUControl` codes outside the ALU's set pass through unchanged.

## Timing
- Latency of 1 cycle: an operation accepted at edge N is on `OutValid`/`A`/`B` after edge N.
- Throughput is 1 op/cycle while `OutReady`=1.
- With `OutReady` held low, the stage absorbs exactly 2 ops, then drops `InReady`.
- Head outputs are stable while `OutValid & !OutReady`.
- **Reset (asynchronous assert):** all entries invalid, `OutValid`=0, `InReady`=1, `ALUControl`/`A`/`B`/`OutRd`=0, `OutRegWrite`=0. A reset mid-transfer discards all content.
- **Reset release:** synchronous to `clk`; first acceptance is possible at the first edge after deassertion.

## Structure
- **Shared package `riscv_pkg`:**
  - `alu_op_t` enum with values 0/1/2/6/7/12, so the ALU and this stage share one encoding.
  - `issue_entry_t` struct: `ALUControl`, A, B, Rd, RegWrite.
  - `XLEN`/`REGW` defaults.
- **Sub-module `riscv_fwd_mux`:** one combinational forwarding selector, instantiated twice (rs1, rs2).
- The skid buffer stays inline.

## Test plan
- **Reset and single ADD.**
  - Stimulus: reset, then `InALUControl`=2, Rs1Val=5, Rs2Val=7, ALUSrc=0, no forwarding.
  - Response: one cycle later `OutValid`=1, A=5, B=7, ALUControl=2.
- **Forwarding priority.**
  - Stimulus: Rs1=3, MEM (Rd 3, 0xAA) and WB (Rd 3, 0xBB) both valid.
  - Response: A=0xAA. Repeat with MEM RegWrite=0: A=0xBB. Repeat with Rs1=0 and both producers targeting Rd 0: A=`InRs1Val`.
- **Immediate select.**
  - Stimulus: ALUSrc=1, Imm=0xFFFF_FFFF_FFFF_FFF0, MEM forwarding matches Rs2.
  - Response: B=0xFFFF_FFFF_FFFF_FFF0.
- **Backpressure.**
  - Stimulus: `OutReady`=0, present ops X, Y, Z on consecutive cycles.
  - Response: X and Y accepted and Z stalled (`InReady`=0 after Y). Raise `OutReady`: output order X, Y, Z, with no loss or duplication.
- **Flush while full plus input.**
  - Stimulus: assert `Flush` while full, with `InValid`=1 in the same cycle.
  - Response: next cycle `OutValid`=0, `InReady`=1, and the input is dropped.
- **Asynchronous reset mid-stream.**
  - Stimulus: assert `reset` between edges with 2 entries buffered.
  - Response: `OutValid`=0 and A=B=0 immediately, before the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the ALU and the stages around it.
//   XLEN / REGW    : default datapath and register-index widths
//   alu_op_t       : ALU operation encoding, common to the ALU and the issue stage
//   issue_entry_t  : one buffered operation as presented to the ALU
//   buf_state_t    : occupancy of the issue-stage skid buffer
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_t;

  // alu_control is kept as a raw 4-bit code rather than alu_op_t so that
  // codes the ALU does not define still pass through untouched.
  typedef struct packed {
    logic [3:0]      alu_control;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [REGW-1:0] rd;
    logic            reg_write;
  } issue_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/riscv_fwd_mux.sv
// -----------------------------------------------------------------------------
// riscv_fwd_mux
// Combinational operand forwarding selector for one source register.
//   rs        : source register index
//   rf_val    : register-file read value
//   m_we/m_rd/m_res : MEM-stage producer (highest priority)
//   w_we/w_rd/w_res : WB-stage producer
//   val       : resolved operand
// x0 is hard-wired to zero in the register file, so a producer targeting x0
// never forwards.
// -----------------------------------------------------------------------------
module riscv_fwd_mux #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = riscv_pkg::REGW
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            m_we,
  input  logic [REGW-1:0] m_rd,
  input  logic [XLEN-1:0] m_res,
  input  logic            w_we,
  input  logic [REGW-1:0] w_rd,
  input  logic [XLEN-1:0] w_res,
  output logic [XLEN-1:0] val
);

  logic rs_nonzero;
  logic hit_m;
  logic hit_w;

  assign rs_nonzero = (rs != '0);
  assign hit_m      = m_we & (m_rd == rs) & rs_nonzero;
  assign hit_w      = w_we & (w_rd == rs) & rs_nonzero;

  // MEM is the younger producer, so it wins over WB.
  assign val = hit_m ? m_res :
               hit_w ? w_res : rf_val;

endmodule

// File: rtl/riscv_alu_issue.sv
// -----------------------------------------------------------------------------
// riscv_alu_issue
// Registered issue stage in front of the 64-bit ALU. Operands are resolved
// (forwarding + immediate select) once, when an operation is accepted, and the
// result is held in a two-entry skid buffer (head + skid).
//   clk, reset                : clock, asynchronous active-high reset
//   InValid/InReady           : decode-side handshake
//   InALUControl, InRs1Val, InRs2Val, InImm, InALUSrc,
//   InRs1, InRs2, InRd, InRegWrite : decoded operation
//   FwdM*/FwdW*               : MEM / WB producers for forwarding
//   Flush                     : drop all buffered and incoming operations
//   OutValid/OutReady         : ALU-side handshake
//   ALUControl, A, B, OutRd, OutRegWrite : head entry fields
// The entry struct uses the package widths, so XLEN/REGW must stay at the
// package defaults.
// -----------------------------------------------------------------------------
module riscv_alu_issue #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = riscv_pkg::REGW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [3:0]      InALUControl,
  input  logic [XLEN-1:0] InRs1Val,
  input  logic [XLEN-1:0] InRs2Val,
  input  logic [XLEN-1:0] InImm,
  input  logic            InALUSrc,
  input  logic [REGW-1:0] InRs1,
  input  logic [REGW-1:0] InRs2,
  input  logic [REGW-1:0] InRd,
  input  logic            InRegWrite,
  input  logic            FwdMRegWrite,
  input  logic [REGW-1:0] FwdMRd,
  input  logic [XLEN-1:0] FwdMResult,
  input  logic            FwdWRegWrite,
  input  logic [REGW-1:0] FwdWRd,
  input  logic [XLEN-1:0] FwdWResult,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [3:0]      ALUControl,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [REGW-1:0] OutRd,
  output logic            OutRegWrite
);

  import riscv_pkg::*;

  // ---------------------------------------------------------------------------
  // Operand resolution
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  issue_entry_t    in_entry;

  riscv_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .rs     (InRs1),
    .rf_val (InRs1Val),
    .m_we   (FwdMRegWrite),
    .m_rd   (FwdMRd),
    .m_res  (FwdMResult),
    .w_we   (FwdWRegWrite),
    .w_rd   (FwdWRd),
    .w_res  (FwdWResult),
    .val    (fwd_a)
  );

  riscv_fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .rs     (InRs2),
    .rf_val (InRs2Val),
    .m_we   (FwdMRegWrite),
    .m_rd   (FwdMRd),
    .m_res  (FwdMResult),
    .w_we   (FwdWRegWrite),
    .w_rd   (FwdWRd),
    .w_res  (FwdWResult),
    .val    (fwd_b)
  );

  // The immediate replaces B outright; any rs2 forwarding match is ignored.
  assign in_entry = '{
    alu_control: InALUControl,
    a:           fwd_a,
    b:           InALUSrc ? InImm : fwd_b,
    rd:          InRd,
    reg_write:   InRegWrite
  };

  // ---------------------------------------------------------------------------
  // Skid buffer control
  // ---------------------------------------------------------------------------
  buf_state_t   state_q;
  buf_state_t   state_d;
  logic         in_ready_q;
  issue_entry_t head_q;
  issue_entry_t skid_q;
  logic         in_xfer;
  logic         out_xfer;
  logic         load_head_in;
  logic         load_head_skid;
  logic         load_skid;

  // An input offered during a flush is dropped even when InReady is high.
  assign in_xfer  = InValid & in_ready_q & ~Flush;
  assign out_xfer = (state_q != BUF_EMPTY) & OutReady;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (Flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (in_xfer) begin
            load_head_in = 1'b1;
            state_d      = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_xfer && out_xfer) begin
            load_head_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = BUF_FULL;
          end else if (out_xfer) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // in_ready_q is low here, so only the output side can move.
          if (out_xfer) begin
            load_head_skid = 1'b1;
            state_d        = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Registered so InReady never depends combinationally on OutReady.
      in_ready_q <= (state_d != BUF_FULL);
    end
  end

  // NOTE: the two entries are reset as well as the state, because the head
  // drives the ALU operands directly and must read as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= in_entry;
      end else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign InReady     = in_ready_q;
  assign OutValid    = (state_q != BUF_EMPTY);
  assign ALUControl  = head_q.alu_control;
  assign A           = head_q.a;
  assign B           = head_q.b;
  assign OutRd       = head_q.rd;
  assign OutRegWrite = head_q.reg_write;

endmodule

// File: tb/tb_riscv_alu_issue.sv
module tb_riscv_alu_issue;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            InValid;
  logic            InReady;
  logic [3:0]      InALUControl;
  logic [XLEN-1:0] InRs1Val, InRs2Val, InImm;
  logic            InALUSrc;
  logic [REGW-1:0] InRs1, InRs2, InRd;
  logic            InRegWrite;
  logic            FwdMRegWrite;
  logic [REGW-1:0] FwdMRd;
  logic [XLEN-1:0] FwdMResult;
  logic            FwdWRegWrite;
  logic [REGW-1:0] FwdWRd;
  logic [XLEN-1:0] FwdWResult;
  logic            Flush;
  logic            OutValid;
  logic            OutReady;
  logic [3:0]      ALUControl;
  logic [XLEN-1:0] A, B;
  logic [REGW-1:0] OutRd;
  logic            OutRegWrite;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [REGW-1:0] rd;
    logic            we;
  } exp_t;

  // Reference model: a FIFO of at most two resolved operations.
  exp_t model_q[$];

  riscv_alu_issue #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk          (clk),
    .reset        (reset),
    .InValid      (InValid),
    .InReady      (InReady),
    .InALUControl (InALUControl),
    .InRs1Val     (InRs1Val),
    .InRs2Val     (InRs2Val),
    .InImm        (InImm),
    .InALUSrc     (InALUSrc),
    .InRs1        (InRs1),
    .InRs2        (InRs2),
    .InRd         (InRd),
    .InRegWrite   (InRegWrite),
    .FwdMRegWrite (FwdMRegWrite),
    .FwdMRd       (FwdMRd),
    .FwdMResult   (FwdMResult),
    .FwdWRegWrite (FwdWRegWrite),
    .FwdWRd       (FwdWRd),
    .FwdWResult   (FwdWResult),
    .Flush        (Flush),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .ALUControl   (ALUControl),
    .A            (A),
    .B            (B),
    .OutRd        (OutRd),
    .OutRegWrite  (OutRegWrite)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [XLEN-1:0] resolve(input logic [REGW-1:0] rs,
                                              input logic [XLEN-1:0] rf);
    if (rs != 0 && FwdMRegWrite && FwdMRd == rs) return FwdMResult;
    if (rs != 0 && FwdWRegWrite && FwdWRd == rs) return FwdWResult;
    return rf;
  endfunction

  task automatic set_idle();
    InValid = 0; InALUControl = 0; InRs1Val = 0; InRs2Val = 0; InImm = 0;
    InALUSrc = 0; InRs1 = 0; InRs2 = 0; InRd = 0; InRegWrite = 0;
    FwdMRegWrite = 0; FwdMRd = 0; FwdMResult = 0;
    FwdWRegWrite = 0; FwdWRd = 0; FwdWResult = 0;
    Flush = 0; OutReady = 0;
  endtask

  task automatic offer(input logic [3:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [REGW-1:0] rd);
    InValid = 1; InALUControl = op; InRs1Val = a; InRs2Val = b;
    InRs1 = 0; InRs2 = 0; InALUSrc = 0; InRd = rd; InRegWrite = 1;
  endtask

  // One clock: the model follows the edge, then we return on the next negedge.
  task automatic tick();
    exp_t e;
    bit   in_rdy, out_x, in_x;
    @(posedge clk);
    in_rdy = model_q.size() < 2;
    out_x  = model_q.size() > 0 && OutReady;
    in_x   = InValid && in_rdy && !Flush;
    e.op = InALUControl;
    e.a  = resolve(InRs1, InRs1Val);
    e.b  = InALUSrc ? InImm : resolve(InRs2, InRs2Val);
    e.rd = InRd;
    e.we = InRegWrite;
    if (Flush) model_q.delete();
    else begin
      if (out_x) void'(model_q.pop_front());
      if (in_x) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    InValid = 0; Flush = 0; OutReady = 1;
    tick(); tick();
    OutReady = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %0b want 0", OutValid); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %0b want 1", InReady); end
    checks++; if ({ALUControl, A, B, OutRd, OutRegWrite} !== '0) begin errors++;
      $display("FAIL reset_fields: got ctl=%0h A=%0h B=%0h rd=%0d we=%0b want all 0", ALUControl, A, B, OutRd, OutRegWrite); end
    @(negedge clk);
    reset = 0;
    model_q.delete();
  endtask

  task automatic test_add();
    offer(4'd2, 64'd5, 64'd7, 5'd4);
    tick();
    InValid = 0;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", OutValid); end
    checks++; if (A !== 64'd5 || B !== 64'd7) begin errors++; $display("FAIL add_ab: got A=%0d B=%0d want 5 7", A, B); end
    checks++; if (ALUControl !== 4'd2 || OutRd !== 5'd4 || OutRegWrite !== 1'b1) begin errors++;
      $display("FAIL add_ctl: got ctl=%0d rd=%0d we=%0b want 2 4 1", ALUControl, OutRd, OutRegWrite); end
    drain();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL add_drained: got %0b want 0", OutValid); end
  endtask

  task automatic test_fwd_priority();
    logic            mwe  [3] = '{1'b1, 1'b0, 1'b1};
    logic [REGW-1:0] rs   [3] = '{5'd3, 5'd3, 5'd0};
    logic [XLEN-1:0] expa [3] = '{64'hAA, 64'hBB, 64'h1234};
    logic [XLEN-1:0] expb [3] = '{64'hAA, 64'hBB, 64'h5678};
    for (int i = 0; i < 3; i++) begin
      offer(4'd2, 64'h1234, 64'h5678, 5'd1);
      InRs1 = rs[i]; InRs2 = rs[i];
      FwdMRegWrite = mwe[i]; FwdMRd = rs[i]; FwdMResult = 64'hAA;
      FwdWRegWrite = 1'b1;   FwdWRd = rs[i]; FwdWResult = 64'hBB;
      tick();
      set_idle();
      checks++; if (A !== expa[i]) begin errors++; $display("FAIL fwd_a[%0d]: got %0h want %0h", i, A, expa[i]); end
      checks++; if (B !== expb[i]) begin errors++; $display("FAIL fwd_b[%0d]: got %0h want %0h", i, B, expb[i]); end
      drain();
    end
  endtask

  task automatic test_imm();
    offer(4'd0, 64'd9, 64'd3, 5'd2);
    InALUSrc = 1; InImm = 64'hFFFF_FFFF_FFFF_FFF0;
    InRs2 = 5'd5; FwdMRegWrite = 1; FwdMRd = 5'd5; FwdMResult = 64'hDEAD;
    tick();
    set_idle();
    checks++; if (B !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL imm_b: got %0h want fffffffffffffff0", B); end
    checks++; if (A !== 64'd9 || ALUControl !== 4'd0) begin errors++; $display("FAIL imm_a: got A=%0d ctl=%0d want 9 0", A, ALUControl); end
    drain();
  endtask

  task automatic test_backpressure();
    set_idle();
    offer(4'd2, 64'h11, 64'h1, 5'd1); tick();
    checks++; if (InReady !== 1'b1 || OutValid !== 1'b1 || A !== 64'h11) begin errors++;
      $display("FAIL bp_x: got rdy=%0b vld=%0b A=%0h want 1 1 11", InReady, OutValid, A); end
    offer(4'd6, 64'h22, 64'h2, 5'd2); tick();
    checks++; if (InReady !== 1'b0 || A !== 64'h11) begin errors++; $display("FAIL bp_y: got rdy=%0b A=%0h want 0 11", InReady, A); end
    offer(4'd7, 64'h33, 64'h3, 5'd3); tick();
    checks++; if (InReady !== 1'b0 || A !== 64'h11 || ALUControl !== 4'd2) begin errors++;
      $display("FAIL bp_stall: got rdy=%0b A=%0h ctl=%0d want 0 11 2", InReady, A, ALUControl); end
    OutReady = 1; tick();
    checks++; if (A !== 64'h22 || ALUControl !== 4'd6 || InReady !== 1'b1) begin errors++;
      $display("FAIL bp_out_y: got A=%0h ctl=%0d rdy=%0b want 22 6 1", A, ALUControl, InReady); end
    tick();
    checks++; if (A !== 64'h33 || ALUControl !== 4'd7 || OutValid !== 1'b1) begin errors++;
      $display("FAIL bp_out_z: got A=%0h ctl=%0d vld=%0b want 33 7 1", A, ALUControl, OutValid); end
    InValid = 0; tick();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bp_nodup: got %0b want 0", OutValid); end
    set_idle();
  endtask

  task automatic test_flush();
    set_idle();
    offer(4'd1, 64'h41, 64'h1, 5'd1); tick();
    offer(4'd1, 64'h42, 64'h2, 5'd2); tick();
    offer(4'd1, 64'h99, 64'h9, 5'd9); Flush = 1; tick();
    Flush = 0; InValid = 0;
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++;
      $display("FAIL flush_state: got vld=%0b rdy=%0b want 0 1", OutValid, InReady); end
    tick();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %0b want 0", OutValid); end
    set_idle();
  endtask

  task automatic test_async_reset();
    set_idle();
    offer(4'd2, 64'hA1, 64'hB1, 5'd1); tick();
    offer(4'd2, 64'hA2, 64'hB2, 5'd2); tick();
    set_idle();
    #2 reset = 1;
    #1;
    checks++; if (OutValid !== 1'b0 || A !== '0 || B !== '0) begin errors++;
      $display("FAIL async_reset: got vld=%0b A=%0h B=%0h want 0 0 0", OutValid, A, B); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL async_reset_rdy: got %0b want 1", InReady); end
    model_q.delete();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_random();
    exp_t h;
    for (int n = 0; n < 400; n++) begin
      checks++; if (OutValid !== (model_q.size() > 0)) begin errors++;
        $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, OutValid, model_q.size() > 0); end
      checks++; if (InReady !== (model_q.size() < 2)) begin errors++;
        $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, InReady, model_q.size() < 2); end
      if (model_q.size() > 0) begin
        h = model_q[0];
        checks++;
        if ({ALUControl, A, B, OutRd, OutRegWrite} !== {h.op, h.a, h.b, h.rd, h.we}) begin errors++;
          $display("FAIL rnd_head[%0d]: got ctl=%0h A=%0h B=%0h rd=%0d we=%0b want ctl=%0h A=%0h B=%0h rd=%0d we=%0b",
                   n, ALUControl, A, B, OutRd, OutRegWrite, h.op, h.a, h.b, h.rd, h.we);
        end
      end
      InValid      = ($urandom_range(0, 3) != 0);
      OutReady     = ($urandom_range(0, 2) != 0);
      Flush        = ($urandom_range(0, 19) == 0);
      InALUControl = 4'($urandom_range(0, 15));
      InRs1Val     = {$urandom, $urandom};
      InRs2Val     = {$urandom, $urandom};
      InImm        = {$urandom, $urandom};
      InALUSrc     = 1'($urandom_range(0, 1));
      InRs1        = 5'($urandom_range(0, 3));
      InRs2        = 5'($urandom_range(0, 3));
      InRd         = 5'($urandom_range(0, 31));
      InRegWrite   = 1'($urandom_range(0, 1));
      FwdMRegWrite = 1'($urandom_range(0, 1));
      FwdMRd       = 5'($urandom_range(0, 3));
      FwdMResult   = {$urandom, $urandom};
      FwdWRegWrite = 1'($urandom_range(0, 1));
      FwdWRd       = 5'($urandom_range(0, 3));
      FwdWResult   = {$urandom, $urandom};
      tick();
    end
    set_idle();
    drain();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %0b want 0", OutValid); end
  endtask

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_add();
    test_fwd_priority();
    test_imm();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
